alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered ALU-decode pipeline stage between instruction decode and execute. It maps funct3/funct7 plus an R/I-type flag to an ALU function code, with optional RV32M decode and illegal-encoding detection. Output goes through a 2-entry skid buffer with valid/ready handshakes on both sides. A saturating illegal-encoding counter is provided for debug.

## Interface
- FUNCT3_WIDTH, 3, funct3 field width
- FUNCT7_WIDTH, 7, funct7 field width
- ALU_FUNCT_WIDTH, 4, ALU function code width
- EN_M, 1, 1 = decode funct7=0000001 as RV32M; 0 = such encodings are illegal
- TAG_WIDTH, 5, opaque side-band tag (e.g. rd) carried with each entry
- CNT_WIDTH, 8, illegal counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, a function of state only
- in_is_imm  in  1  1 = OP-IMM (I-type), 0 = OP (R-type)
- in_funct3  in  FUNCT3_WIDTH  funct3 field
- in_funct7  in  FUNCT7_WIDTH  funct7 field (imm[11:5] for I-type)
- in_tag  in  TAG_WIDTH  side-band tag
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_alu_funct  out  ALU_FUNCT_WIDTH  decoded function code
- out_is_mul  out  1  entry is an M-extension op; out_alu_funct[2:0] = funct3
- out_illegal  out  1  encoding illegal; out_alu_funct forced to ADD
- out_tag  out  TAG_WIDTH  tag of output entry
- illegal_count  out  CNT_WIDTH  accepted illegal entries, saturating

## Operation
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9. Codes 10–15 unused.
- R-type, funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- R-type, funct7=0100000: funct3 000 SUB, 101 SRA; any other funct3 is illegal.
- R-type, funct7=0000001: if EN_M, is_mul=1 and alu_funct = {0, funct3}; otherwise illegal.
- R-type, any other funct7: illegal.
- I-type: funct3 000/010/011/100/110/111 decode to ADD/SLT/SLTU/XOR/OR/AND, with funct7 ignored.
- I-type 001: SLL only if funct7=0000000, else illegal.
- I-type 101: funct7 0000000 gives SRL, 0100000 gives SRA, else illegal. There is no SUBI.
- Illegal entries: alu_funct=ADD (0), is_mul=0, illegal=1. Entry still flows downstream with its tag.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1
  - ONE: out reg valid, in_ready=1
  - FULL: out and skid regs valid, in_ready=0
- Transitions (accept = in_valid&in_ready, drain = out_valid&out_ready):
  - EMPTY + accept → ONE
  - ONE + accept & !drain → FULL (new entry into skid)
  - ONE + accept & drain → ONE (out reg reloaded)
  - ONE + drain only → EMPTY
  - FULL + drain → ONE (skid moves to out reg)
- Order is strictly FIFO; out_* are stable while out_valid & !out_ready.
- illegal_count increments by 1 on each accepted illegal entry and holds at 2^CNT_WIDTH−1. It is not cleared by flush.
- flush: next state EMPTY. An entry presented in the flush cycle is neither accepted nor counted. A drain in the flush cycle still counts as a downstream transfer.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 entry per cycle with out_ready held high.
- in_ready depends only on registered state, with no combinational path from out_ready. A stall costs one cycle of bubble-free buffering.
- Reset values (async assert, sync deassert at the system level): state EMPTY, in_ready=1, out_valid=0, out_alu_funct=0, out_is_mul=0, out_illegal=0, out_tag=0, illegal_count=0.
- Reset mid-stream drops all entries immediately.
- flush and reset behave identically on state; flush does not clear the counter.

## Structure
- ALU code constants and funct3/funct7 constants belong in the shared defines headers: alu_funct_defines.h (extended with SLTU and the M-op class) and funct_defines.h (adding FUNCT7_MULDIV).
- Combinational sub-module alu_funct_decode:
  - inputs: is_imm, funct3, funct7, parameter EN_M
  - outputs: alu_funct, is_mul, illegal
  - instantiated once on the input side. The skid buffer and counter live in alu_decode_stage.

## Test plan
- Reset: hold rst_n low mid-stream → out_valid=0, in_ready=1, illegal_count=0 immediately.
- Decode sweep, out_ready=1, every R/I funct3 with funct7 ∈ {00, 20, 01}:
  - R 000/20 → SUB(1)
  - I 000/20 → ADD(0)
  - R 101/20 → SRA(9)
  - R 010/20 → illegal
  - R x/01 → is_mul=1, alu_funct=funct3
  - with EN_M=0: R x/01 → illegal
- Backpressure: stream tags 1..6, out_ready low for cycles 2–4 → in_ready falls after two entries are held, tags emerge 1..6 in order with no loss or duplication.
- Counter saturation with CNT_WIDTH=2: accept 5 illegal entries → illegal_count reads 1, 2, 3, 3, 3.
- Flush in FULL with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, the flush-cycle entry is never output, and illegal_count is unchanged.

Source files
------------

// File: rtl/alu_decode_pkg.sv
// alu_decode_pkg: ALU function codes, funct3/funct7 encodings and buffer states shared by the decode stage.
package alu_decode_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9;
  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111;
  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000, FUNCT7_ALT = 7'b0100000, FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2;
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_decode_if.sv
// alu_decode_if: upstream/downstream handshake and decoded-entry bus of the ALU decode stage.
interface alu_decode_if #(
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7,
  parameter int ALU_FUNCT_WIDTH = 4,
  parameter int TAG_WIDTH = 5,
  parameter int CNT_WIDTH = 8
);
  logic in_valid, in_ready, in_is_imm;
  logic [FUNCT3_WIDTH-1:0] in_funct3;
  logic [FUNCT7_WIDTH-1:0] in_funct7;
  logic [TAG_WIDTH-1:0] in_tag;
  logic out_valid, out_ready, out_is_mul, out_illegal;
  logic [ALU_FUNCT_WIDTH-1:0] out_alu_funct;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [CNT_WIDTH-1:0] illegal_count;
  modport slave (
    input in_valid, in_is_imm, in_funct3, in_funct7, in_tag, out_ready,
    output in_ready, out_valid, out_alu_funct, out_is_mul, out_illegal, out_tag, illegal_count
  );
  modport master (
    output in_valid, in_is_imm, in_funct3, in_funct7, in_tag, out_ready,
    input in_ready, out_valid, out_alu_funct, out_is_mul, out_illegal, out_tag, illegal_count
  );
endinterface

// File: rtl/alu_decode_stage_alu_funct_decode.sv
// alu_funct_decode: combinational funct3/funct7 to ALU code mapping with RV32M and illegal detection.
module alu_funct_decode
  import alu_decode_pkg::*;
#(
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7,
  parameter int ALU_FUNCT_WIDTH = 4,
  parameter int EN_M = 1
) (
  input  logic                       is_imm,
  input  logic [FUNCT3_WIDTH-1:0]    funct3,
  input  logic [FUNCT7_WIDTH-1:0]    funct7,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic                       is_mul,
  output logic                       illegal
);
  logic [ALU_FUNCT_WIDTH-1:0] op;
  always_comb begin
    is_mul = 1'b0;
    illegal = 1'b0;
    op = base_op(funct3);
    if (is_imm) begin
      // funct7 is the immediate here, so only the shift encodings constrain it
      illegal = (funct3 == F3_SLL && funct7 != FUNCT7_ZERO) ||
                (funct3 == F3_SR && funct7 != FUNCT7_ZERO && funct7 != FUNCT7_ALT);
      op = (funct3 == F3_SR && funct7 == FUNCT7_ALT) ? ALU_SRA : base_op(funct3);
    end else if (funct7 == FUNCT7_ALT) begin
      illegal = funct3 != F3_ADD && funct3 != F3_SR;
      op = funct3 == F3_ADD ? ALU_SUB : ALU_SRA;
    end else if (funct7 == FUNCT7_MULDIV && EN_M != 0) begin
      is_mul = 1'b1;
      op = {1'b0, funct3};
    end else begin
      illegal = funct7 != FUNCT7_ZERO;
    end
  end
  assign alu_funct = illegal ? ALU_ADD : op;
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered ALU decode with a 2-entry skid buffer and a saturating illegal-encoding counter.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7,
  parameter int ALU_FUNCT_WIDTH = 4,
  parameter int EN_M = 1,
  parameter int TAG_WIDTH = 5,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  alu_decode_if.slave bus
);
  localparam int EW = ALU_FUNCT_WIDTH + 2 + TAG_WIDTH;
  logic [1:0] state, next_state;
  logic [EW-1:0] dec, out_q, skid_q;
  logic [ALU_FUNCT_WIDTH-1:0] d_funct;
  logic d_mul, d_ill, accept, drain, load_out;
  logic [CNT_WIDTH-1:0] count;
  alu_funct_decode #(
    .FUNCT3_WIDTH(FUNCT3_WIDTH), .FUNCT7_WIDTH(FUNCT7_WIDTH),
    .ALU_FUNCT_WIDTH(ALU_FUNCT_WIDTH), .EN_M(EN_M)
  ) u_dec (
    .is_imm(bus.in_is_imm), .funct3(bus.in_funct3), .funct7(bus.in_funct7),
    .alu_funct(d_funct), .is_mul(d_mul), .illegal(d_ill)
  );
  assign dec = {d_funct, d_mul, d_ill, bus.in_tag};
  assign bus.in_ready = state != ST_FULL;
  assign bus.out_valid = state != ST_EMPTY;
  assign accept = bus.in_valid & bus.in_ready & ~flush;
  assign drain = bus.out_valid & bus.out_ready;
  assign load_out = accept & (state == ST_EMPTY | (state == ST_ONE & drain));
  assign {bus.out_alu_funct, bus.out_is_mul, bus.out_illegal, bus.out_tag} = out_q;
  assign bus.illegal_count = count;
  always_comb begin
    next_state = state == ST_EMPTY ? (accept ? ST_ONE : ST_EMPTY) :
                 state == ST_ONE   ? (accept & ~drain ? ST_FULL : ~accept & drain ? ST_EMPTY : ST_ONE) :
                 state == ST_FULL  ? (drain ? ST_ONE : ST_FULL) : ST_EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      out_q <= '0;
      skid_q <= '0;
      count <= '0;
    end else begin
      state <= flush ? ST_EMPTY : next_state;
      out_q <= (state == ST_FULL & drain) ? skid_q : load_out ? dec : out_q;
      skid_q <= (state == ST_ONE & accept & ~drain) ? dec : skid_q;
      if (accept & d_ill & ~&count) count <= count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed decode table plus reset, backpressure, saturation and flush sequences.
module tb_alu_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic in_valid = 1'b0, in_is_imm = 1'b0;
  logic [2:0] in_funct3 = '0;
  logic [6:0] in_funct7 = '0;
  logic [4:0] in_tag = '0;
  int n_vec = 0, n_bad = 0, exp_cnt_a = 0;
  typedef struct {
    logic imm; logic [2:0] f3; logic [6:0] f7; logic [3:0] op; logic mul; logic ill;
  } vec_t;
  vec_t tbl[29];
  int sat[5];

  always #5 clk = ~clk;

  alu_decode_if #(.CNT_WIDTH(8)) bus_a();
  alu_decode_if #(.CNT_WIDTH(2)) bus_b();
  assign bus_a.in_valid = in_valid;
  assign bus_a.in_is_imm = in_is_imm;
  assign bus_a.in_funct3 = in_funct3;
  assign bus_a.in_funct7 = in_funct7;
  assign bus_a.in_tag = in_tag;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_is_imm = in_is_imm;
  assign bus_b.in_funct3 = in_funct3;
  assign bus_b.in_funct7 = in_funct7;
  assign bus_b.in_tag = in_tag;
  assign bus_b.out_ready = out_ready;

  alu_decode_stage #(.EN_M(1), .CNT_WIDTH(8)) u_a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a));
  alu_decode_stage #(.EN_M(0), .CNT_WIDTH(2)) u_b (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic imm, input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] tag);
    in_valid = v;
    in_is_imm = imm;
    in_funct3 = f3;
    in_funct7 = f7;
    in_tag = tag;
  endtask

  initial begin
    int got, next_tag;
    tbl = '{
      '{1'b0, 3'b000, 7'h00, 4'd0, 1'b0, 1'b0}, '{1'b0, 3'b001, 7'h00, 4'd7, 1'b0, 1'b0},
      '{1'b0, 3'b010, 7'h00, 4'd5, 1'b0, 1'b0}, '{1'b0, 3'b011, 7'h00, 4'd6, 1'b0, 1'b0},
      '{1'b0, 3'b100, 7'h00, 4'd4, 1'b0, 1'b0}, '{1'b0, 3'b101, 7'h00, 4'd8, 1'b0, 1'b0},
      '{1'b0, 3'b110, 7'h00, 4'd3, 1'b0, 1'b0}, '{1'b0, 3'b111, 7'h00, 4'd2, 1'b0, 1'b0},
      '{1'b0, 3'b000, 7'h20, 4'd1, 1'b0, 1'b0}, '{1'b0, 3'b101, 7'h20, 4'd9, 1'b0, 1'b0},
      '{1'b0, 3'b010, 7'h20, 4'd0, 1'b0, 1'b1}, '{1'b0, 3'b111, 7'h20, 4'd0, 1'b0, 1'b1},
      '{1'b0, 3'b000, 7'h01, 4'd0, 1'b1, 1'b0}, '{1'b0, 3'b011, 7'h01, 4'd3, 1'b1, 1'b0},
      '{1'b0, 3'b111, 7'h01, 4'd7, 1'b1, 1'b0}, '{1'b0, 3'b000, 7'h05, 4'd0, 1'b0, 1'b1},
      '{1'b1, 3'b000, 7'h00, 4'd0, 1'b0, 1'b0}, '{1'b1, 3'b000, 7'h20, 4'd0, 1'b0, 1'b0},
      '{1'b1, 3'b010, 7'h01, 4'd5, 1'b0, 1'b0}, '{1'b1, 3'b011, 7'h20, 4'd6, 1'b0, 1'b0},
      '{1'b1, 3'b100, 7'h00, 4'd4, 1'b0, 1'b0}, '{1'b1, 3'b110, 7'h01, 4'd3, 1'b0, 1'b0},
      '{1'b1, 3'b111, 7'h20, 4'd2, 1'b0, 1'b0}, '{1'b1, 3'b001, 7'h00, 4'd7, 1'b0, 1'b0},
      '{1'b1, 3'b001, 7'h20, 4'd0, 1'b0, 1'b1}, '{1'b1, 3'b101, 7'h00, 4'd8, 1'b0, 1'b0},
      '{1'b1, 3'b101, 7'h20, 4'd9, 1'b0, 1'b0}, '{1'b1, 3'b101, 7'h01, 4'd0, 1'b0, 1'b1},
      '{1'b1, 3'b001, 7'h01, 4'd0, 1'b0, 1'b1}
    };
    sat = '{1, 2, 3, 3, 3};

    repeat (2) cyc();
    chk("rst out_valid", 32'(bus_a.out_valid), 0);
    chk("rst in_ready", 32'(bus_a.in_ready), 1);
    chk("rst alu_funct", 32'(bus_a.out_alu_funct), 0);
    chk("rst is_mul", 32'(bus_a.out_is_mul), 0);
    chk("rst illegal", 32'(bus_a.out_illegal), 0);
    chk("rst tag", 32'(bus_a.out_tag), 0);
    chk("rst count", 32'(bus_a.illegal_count), 0);
    #3 rst_n = 1'b1;

    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 7'h20, 5'd3);
    cyc();
    drive(1'b1, 1'b0, 3'b000, 7'h00, 5'd4);
    cyc();
    in_valid = 1'b0;
    chk("pre-rst in_ready", 32'(bus_a.in_ready), 0);
    chk("pre-rst count", 32'(bus_a.illegal_count), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus_a.out_valid), 0);
    chk("midrst in_ready", 32'(bus_a.in_ready), 1);
    chk("midrst count", 32'(bus_a.illegal_count), 0);
    chk("midrst tag", 32'(bus_a.out_tag), 0);
    out_ready = 1'b1;
    cyc();
    #3 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 3'b010, 7'h20, 5'(i));
      cyc();
      chk($sformatf("sat%0d count_b", i), 32'(bus_b.illegal_count), 32'(sat[i]));
      chk($sformatf("sat%0d count_a", i), 32'(bus_a.illegal_count), 32'(i + 1));
    end
    exp_cnt_a = 5;
    in_valid = 1'b0;
    cyc();

    for (int i = 0; i < 29; i++) begin
      drive(1'b1, tbl[i].imm, tbl[i].f3, tbl[i].f7, 5'(i));
      cyc();
      exp_cnt_a += int'(tbl[i].ill);
      chk($sformatf("vec%0d valid", i), 32'(bus_a.out_valid), 1);
      chk($sformatf("vec%0d op", i), 32'(bus_a.out_alu_funct), 32'(tbl[i].op));
      chk($sformatf("vec%0d mul", i), 32'(bus_a.out_is_mul), 32'(tbl[i].mul));
      chk($sformatf("vec%0d ill", i), 32'(bus_a.out_illegal), 32'(tbl[i].ill));
      chk($sformatf("vec%0d tag", i), 32'(bus_a.out_tag), 32'(i));
      chk($sformatf("vec%0d count", i), 32'(bus_a.illegal_count), 32'(exp_cnt_a));
      chk($sformatf("vec%0d op noM", i), 32'(bus_b.out_alu_funct), tbl[i].mul ? 0 : 32'(tbl[i].op));
      chk($sformatf("vec%0d mul noM", i), 32'(bus_b.out_is_mul), 0);
      chk($sformatf("vec%0d ill noM", i), 32'(bus_b.out_illegal), 32'(tbl[i].ill | tbl[i].mul));
      chk($sformatf("vec%0d count noM", i), 32'(bus_b.illegal_count), 3);
    end
    in_valid = 1'b0;
    cyc();

    got = 0;
    next_tag = 1;
    for (int c = 0; c < 12; c++) begin
      drive(next_tag <= 6, 1'b1, 3'b000, 7'h00, 5'(next_tag));
      out_ready = !(c >= 2 && c <= 4);
      chk($sformatf("bp c%0d in_ready", c), 32'(bus_a.in_ready), (c >= 3 && c <= 5) ? 0 : 1);
      if (c >= 2 && c <= 4) chk($sformatf("bp c%0d held tag", c), 32'(bus_a.out_tag), 2);
      if (bus_a.out_valid && out_ready) begin
        chk($sformatf("bp c%0d order", c), 32'(bus_a.out_tag), 32'(got + 1));
        got++;
      end
      if (in_valid && bus_a.in_ready) next_tag++;
      cyc();
    end
    in_valid = 1'b0;
    chk("bp drained", 32'(got), 6);
    chk("bp sent", 32'(next_tag), 7);
    chk("bp empty", 32'(bus_a.out_valid), 0);

    out_ready = 1'b0;
    drive(1'b1, 1'b1, 3'b100, 7'h00, 5'd10);
    cyc();
    drive(1'b1, 1'b1, 3'b100, 7'h00, 5'd11);
    cyc();
    chk("fl full", 32'(bus_a.in_ready), 0);
    drive(1'b1, 1'b0, 3'b010, 7'h20, 5'd12);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl out_valid", 32'(bus_a.out_valid), 0);
    chk("fl in_ready", 32'(bus_a.in_ready), 1);
    chk("fl count", 32'(bus_a.illegal_count), 32'(exp_cnt_a));
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("fl idle%0d", c), 32'(bus_a.out_valid), 0);
    end
    drive(1'b1, 1'b0, 3'b000, 7'h20, 5'd13);
    cyc();
    in_valid = 1'b0;
    chk("fl next valid", 32'(bus_a.out_valid), 1);
    chk("fl next tag", 32'(bus_a.out_tag), 13);
    chk("fl next op", 32'(bus_a.out_alu_funct), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
